// File: rtl/manycore_eva_npa_xlate_if.sv
// Request/result bundle between the vanilla core remote path and the
// EVA->NPA translator. The master side issues EVAs and tile-group context;
// the slave side (translator) returns coordinates, EPA and the invalid flag.
interface manycore_eva_npa_xlate_if #(
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 28,
    parameter int x_cord_width_p = 6,
    parameter int y_cord_width_p = 5
);
    logic                      v_i;
    logic [data_width_p-1:0]   eva_i;
    logic                      dram_enable_i;
    logic [x_cord_width_p-1:0] tgo_x_i;
    logic [y_cord_width_p-1:0] tgo_y_i;
    logic [x_cord_width_p-1:0] tg_dim_x_i;
    logic [y_cord_width_p-1:0] tg_dim_y_i;

    logic                      v_o;
    logic [x_cord_width_p-1:0] x_cord_o;
    logic [y_cord_width_p-1:0] y_cord_o;
    logic [addr_width_p-1:0]   epa_o;
    logic                      is_invalid_addr_o;

    modport master (
        output v_i, eva_i, dram_enable_i, tgo_x_i, tgo_y_i, tg_dim_x_i, tg_dim_y_i,
        input  v_o, x_cord_o, y_cord_o, epa_o, is_invalid_addr_o
    );

    modport slave (
        input  v_i, eva_i, dram_enable_i, tgo_x_i, tgo_y_i, tg_dim_x_i, tg_dim_y_i,
        output v_o, x_cord_o, y_cord_o, epa_o, is_invalid_addr_o
    );
endinterface

// File: rtl/manycore_eva_npa_xlate.sv
// Registered EVA -> NPA translator. Classifies a byte EVA as DRAM (hashed
// or direct vcache), global, tile-group or local, and produces destination
// x/y, word EPA and an invalid flag one cycle later. Invalid results carry
// zero coordinates and EPA so nothing stray reaches the packet builder.
module manycore_eva_npa_xlate #(
    parameter int data_width_p                 = 32,
    parameter int addr_width_p                 = 28,
    parameter int x_cord_width_p               = 6,
    parameter int y_cord_width_p               = 5,
    parameter int num_tiles_x_p                = 4,
    parameter int num_tiles_y_p                = 4,
    parameter int vcache_block_size_in_words_p = 8,
    parameter int vcache_size_p                = 2048,
    parameter int vcache_sets_p                = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    manycore_eva_npa_xlate_if.slave   xlate_if
);
    localparam int B = $clog2(vcache_block_size_in_words_p);
    localparam int C = $clog2(num_tiles_x_p);
    localparam int V = $clog2(vcache_size_p);

    localparam logic [31:0] BLK_MASK   = 32'(vcache_block_size_in_words_p - 1);
    localparam logic [31:0] TILE_MASK  = 32'(num_tiles_x_p - 1);
    localparam logic [31:0] VC_MASK    = 32'(vcache_size_p - 1);
    localparam logic [y_cord_width_p-1:0] DRAM_Y = y_cord_width_p'(num_tiles_y_p + 1);

    logic [31:0]               eva;
    logic [31:0]               w32;
    logic [31:0]               lo31;

    logic [x_cord_width_p-1:0] x_xl;
    logic [y_cord_width_p-1:0] y_xl;
    logic [addr_width_p-1:0]   epa_xl;
    logic                      inv_xl;

    logic                      v_d,   v_q;
    logic [x_cord_width_p-1:0] x_d,   x_q;
    logic [y_cord_width_p-1:0] y_d,   y_q;
    logic [addr_width_p-1:0]   epa_d, epa_q;
    logic                      inv_d, inv_q;

    assign eva  = 32'(xlate_if.eva_i);
    assign w32  = {3'b000, eva[30:2]};
    assign lo31 = {1'b0, eva[30:0]};

    // Decode the EVA class and compute the raw translation for this cycle.
    always_comb begin
        x_xl   = '0;
        y_xl   = '0;
        epa_xl = '0;
        inv_xl = 1'b0;
        if (eva[31]) begin
            y_xl = DRAM_Y;
            if (xlate_if.dram_enable_i) begin
                // Block striping: block-index low bits pick the vcache column,
                // the remaining word bits are squeezed together to form the EPA.
                x_xl   = x_cord_width_p'((w32 >> B) & TILE_MASK);
                epa_xl = addr_width_p'(((w32 >> (B + C)) << B) | (w32 & BLK_MASK));
            end else begin
                x_xl   = x_cord_width_p'(eva >> (2 + V));
                epa_xl = addr_width_p'((eva >> 2) & VC_MASK);
                inv_xl = (32'(x_xl) >= 32'(num_tiles_x_p))
                       || ((lo31 >> (2 + V + x_cord_width_p)) != 32'd0);
            end
        end else if (eva[30]) begin
            y_xl   = y_cord_width_p'(32'(eva[29:24]));
            x_xl   = x_cord_width_p'(32'(eva[23:18]));
            epa_xl = addr_width_p'(32'(eva[17:2]));
        end else if (eva[29]) begin
            x_xl   = x_cord_width_p'(32'(xlate_if.tgo_x_i) + 32'(eva[23:18]));
            y_xl   = y_cord_width_p'(32'(xlate_if.tgo_y_i) + 32'(eva[28:24]));
            epa_xl = addr_width_p'(32'(eva[17:2]));
            inv_xl = (32'(eva[23:18]) >= 32'(xlate_if.tg_dim_x_i))
                   || (32'(eva[28:24]) >= 32'(xlate_if.tg_dim_y_i));
        end else begin
            inv_xl = 1'b1;
        end
    end

    // Next-state: load a fresh translation on valid, otherwise hold fields.
    always_comb begin
        v_d   = xlate_if.v_i;
        x_d   = x_q;
        y_d   = y_q;
        epa_d = epa_q;
        inv_d = inv_q;
        if (xlate_if.v_i) begin
            inv_d = inv_xl;
            x_d   = inv_xl ? '0 : x_xl;
            y_d   = inv_xl ? '0 : y_xl;
            epa_d = inv_xl ? '0 : epa_xl;
        end
    end

    // Result register; reset clears both valid and the result fields.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            v_q   <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            epa_q <= '0;
            inv_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            x_q   <= x_d;
            y_q   <= y_d;
            epa_q <= epa_d;
            inv_q <= inv_d;
        end
    end

    assign xlate_if.v_o               = v_q;
    assign xlate_if.x_cord_o          = x_q;
    assign xlate_if.y_cord_o          = y_q;
    assign xlate_if.epa_o             = epa_q;
    assign xlate_if.is_invalid_addr_o = inv_q;
endmodule

// File: tb/tb_manycore_eva_npa_xlate.sv
// Self-checking bench for manycore_eva_npa_xlate: directed cases plus a
// randomized run compared against an arithmetic reference model.
module tb_manycore_eva_npa_xlate;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    manycore_eva_npa_xlate_if #(
        .data_width_p(32), .addr_width_p(28), .x_cord_width_p(6), .y_cord_width_p(5)
    ) bus ();

    manycore_eva_npa_xlate #(
        .data_width_p(32), .addr_width_p(28), .x_cord_width_p(6), .y_cord_width_p(5),
        .num_tiles_x_p(4), .num_tiles_y_p(4), .vcache_block_size_in_words_p(8),
        .vcache_size_p(2048), .vcache_sets_p(64)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .xlate_if(bus.slave)
    );

    // packed result {v(1), x(6), y(5), epa(28), invalid(1)}
    function automatic logic [40:0] pack(input logic v, input int unsigned x, input int unsigned y,
                                         input int unsigned epa, input logic inv);
        logic [5:0]  xx = 6'(x);
        logic [4:0]  yy = 5'(y);
        logic [27:0] ee = 28'(epa);
        return {v, xx, yy, ee, inv};
    endfunction

    // Reference translation written from the address-map rules with plain arithmetic.
    function automatic logic [40:0] model(input logic [31:0] eva, input logic den,
                                          input int unsigned tgx, input int unsigned tgy,
                                          input int unsigned dx, input int unsigned dy);
        int unsigned word, blk, x, y, epa, ox, oy;
        word = {1'b0, eva[30:0]} / 4;
        if (eva[31]) begin
            if (den) begin
                blk = word / 8;
                x   = blk % 4;
                epa = (blk / 4) * 8 + word % 8;
                return pack(1'b1, x, 5, epa, 1'b0);
            end
            x = word / 2048;
            if (x >= 4) return pack(1'b1, 0, 0, 0, 1'b1);
            return pack(1'b1, x, 5, word % 2048, 1'b0);
        end
        if (eva[30])
            return pack(1'b1, (eva / 262144) % 64, (eva / 16777216) % 64, word % 65536, 1'b0);
        if (eva[29]) begin
            ox = (eva / 262144) % 64;
            oy = (eva / 16777216) % 32;
            if (ox >= dx || oy >= dy) return pack(1'b1, 0, 0, 0, 1'b1);
            return pack(1'b1, (tgx + ox) % 64, (tgy + oy) % 32, word % 65536, 1'b0);
        end
        return pack(1'b1, 0, 0, 0, 1'b1);
    endfunction

    function automatic logic [40:0] observed();
        return {bus.v_o, bus.x_cord_o, bus.y_cord_o, bus.epa_o, bus.is_invalid_addr_o};
    endfunction

    function automatic logic [40:0] cur_model(input logic [31:0] eva);
        return model(eva, bus.dram_enable_i, bus.tgo_x_i, bus.tgo_y_i, bus.tg_dim_x_i, bus.tg_dim_y_i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [40:0] got;
        reset_n = 1'b0;
        bus.v_i = 1'b1;
        bus.eva_i = 32'h4304_0010;
        step();
        step();
        got = observed();
        checks++;
        if (got !== 41'd0) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", got, 41'd0);
        end
        bus.v_i = 1'b0;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_dram_enabled();
        logic [31:0] evas [2] = '{32'h8000_0040, 32'h8000_0124};
        logic [40:0] want [2];
        logic [40:0] got;
        want[0] = pack(1'b1, 2, 5, 0, 1'b0);
        want[1] = pack(1'b1, 1, 5, 32'h11, 1'b0);
        bus.dram_enable_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.v_i = 1'b1;
            bus.eva_i = evas[i];
            step();
            got = observed();
            checks++;
            if (got !== want[i]) begin
                errors++;
                $display("FAIL dram_enabled[%0d] got=%h want=%h", i, got, want[i]);
            end
        end
        bus.v_i = 1'b0;
    endtask

    task automatic test_dram_disabled();
        logic [31:0] evas [2] = '{32'h8000_4008, 32'h8008_0000};
        logic [40:0] want [2];
        logic [40:0] got;
        want[0] = pack(1'b1, 2, 5, 2, 1'b0);
        want[1] = pack(1'b1, 0, 0, 0, 1'b1);
        bus.dram_enable_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.v_i = 1'b1;
            bus.eva_i = evas[i];
            step();
            got = observed();
            checks++;
            if (got !== want[i]) begin
                errors++;
                $display("FAIL dram_disabled[%0d] got=%h want=%h", i, got, want[i]);
            end
        end
        bus.v_i = 1'b0;
    endtask

    task automatic test_global();
        logic [40:0] got;
        logic [40:0] want;
        want = pack(1'b1, 1, 3, 4, 1'b0);
        bus.v_i = 1'b1;
        bus.eva_i = 32'h4304_0010;
        step();
        got = observed();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL global got=%h want=%h", got, want);
        end
        bus.v_i = 1'b0;
    endtask

    task automatic test_tile_group();
        logic [31:0] evas [2] = '{32'h2104_0008, 32'h2108_0000};
        logic [40:0] want [2];
        logic [40:0] got;
        want[0] = pack(1'b1, 2, 3, 2, 1'b0);
        want[1] = pack(1'b1, 0, 0, 0, 1'b1);
        bus.tgo_x_i = 6'd1;
        bus.tgo_y_i = 5'd2;
        bus.tg_dim_x_i = 6'd2;
        bus.tg_dim_y_i = 5'd2;
        for (int i = 0; i < 2; i++) begin
            bus.v_i = 1'b1;
            bus.eva_i = evas[i];
            step();
            got = observed();
            checks++;
            if (got !== want[i]) begin
                errors++;
                $display("FAIL tile_group[%0d] got=%h want=%h", i, got, want[i]);
            end
        end
        bus.v_i = 1'b0;
    endtask

    task automatic test_local_hold();
        logic [40:0] got;
        logic [40:0] want;
        bus.v_i = 1'b1;
        bus.eva_i = 32'h4304_0010;
        step();
        bus.eva_i = 32'h0000_1000;
        step();
        want = pack(1'b1, 0, 0, 0, 1'b1);
        got = observed();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL local got=%h want=%h", got, want);
        end
        bus.v_i = 1'b0;
        bus.eva_i = 32'h4304_0010;
        step();
        want = pack(1'b0, 0, 0, 0, 1'b1);
        got = observed();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL idle_hold got=%h want=%h", got, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] evas [3] = '{32'h8000_0124, 32'h4304_0010, 32'h2104_0008};
        logic [40:0] want;
        logic [40:0] got;
        bus.dram_enable_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.v_i = 1'b1;
            bus.eva_i = evas[i];
            want = cur_model(evas[i]);
            step();
            got = observed();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL b2b_pre[%0d] got=%h want=%h", i, got, want);
            end
        end
        bus.eva_i = evas[2];
        reset_n = 1'b0;
        step();
        got = observed();
        checks++;
        if (got !== 41'd0) begin
            errors++;
            $display("FAIL b2b_reset got=%h want=%h", got, 41'd0);
        end
        reset_n = 1'b1;
        want = cur_model(evas[2]);
        step();
        got = observed();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL b2b_resume got=%h want=%h", got, want);
        end
        bus.v_i = 1'b0;
    endtask

    task automatic test_random();
        logic [40:0] want;
        logic [40:0] got;
        logic [40:0] held;
        logic [31:0] eva;
        held = observed();
        for (int n = 0; n < 400; n++) begin
            eva = $urandom;
            case ($urandom_range(0, 3))
                0: begin
                    eva[31] = 1'b1;
                    if ($urandom_range(0, 1) == 0) eva[30:15] = '0;
                end
                1: eva[31:30] = 2'b01;
                2: begin
                    eva[31:29] = 3'b001;
                    eva[23:18] = 6'($urandom_range(0, 7));
                    eva[28:24] = 5'($urandom_range(0, 7));
                end
                default: eva[31:29] = 3'b000;
            endcase
            bus.eva_i = eva;
            bus.v_i = ($urandom_range(0, 3) != 0);
            bus.dram_enable_i = 1'($urandom_range(0, 1));
            bus.tgo_x_i = 6'($urandom);
            bus.tgo_y_i = 5'($urandom);
            bus.tg_dim_x_i = 6'($urandom_range(0, 7));
            bus.tg_dim_y_i = 5'($urandom_range(0, 7));
            if (bus.v_i) want = cur_model(eva);
            else want = {1'b0, held[39:0]};
            step();
            got = observed();
            held = want;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL random[%0d] eva=%h got=%h want=%h", n, eva, got, want);
            end
        end
        bus.v_i = 1'b0;
    endtask

    initial begin
        bus.v_i = 1'b0;
        bus.eva_i = '0;
        bus.dram_enable_i = 1'b1;
        bus.tgo_x_i = '0;
        bus.tgo_y_i = '0;
        bus.tg_dim_x_i = '0;
        bus.tg_dim_y_i = '0;
        test_reset();
        test_dram_enabled();
        test_dram_disabled();
        test_global();
        test_tile_group();
        test_local_hold();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
